inst_fetch_unit: RTL

- Instruction fetch stage sitting directly upstream of the single-cycle R-type decode/execute datapath.
- Drives its 32-bit `inst` input, together with the matching PC.
- Maintains the fetch PC and issues in-order word requests to a variable-latency instruction memory.
- Buffers returned words in a small queue behind a valid/ready handshake, and handles control-flow redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/inst_fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage feeding the R-type decode/execute datapath.
//   clk, rst (async, active-low)
//   fetch_en                                    : permit new memory requests
//   imem_req_valid/ready/addr                   : in-order word requests to instruction memory
//   imem_resp_valid/data                        : responses, returned in request order
//   redirect_valid/redirect_pc                  : restart fetch at a new PC, flushing everything in flight
//   inst_valid/inst_ready/inst/inst_pc          : registered queue head towards decode
module inst_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   CREDITS = (CW + 1)'(QDEPTH);
    localparam logic [CW-1:0] FULL    = CW'(QDEPTH);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state;
    logic [XLEN-1:0]   fetch_pc, resp_pc;
    logic [CW-1:0]     count, outstanding, drop_cnt;
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [31:0]       q_data [QDEPTH];
    logic [XLEN-1:0]   q_pc   [QDEPTH];

    logic              accept, push, pop, dropping;
    logic [CW-1:0]     remain;
    logic [AW-1:0]     rd_next;
    logic [XLEN-1:0]   redirect_base;
    logic              unused_bits;

    assign unused_bits    = ^redirect_pc[1:0];
    assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
    // Every outstanding request already owns a queue slot, so pushes can never overflow.
    assign imem_req_valid = rst & fetch_en & ~redirect_valid &
                            (({1'b0, count} + {1'b0, outstanding}) < CREDITS);
    assign imem_req_addr  = {fetch_pc[XLEN-1:2], 2'b00};
    assign accept         = imem_req_valid & imem_req_ready;
    assign dropping       = drop_cnt != '0;
    assign push           = imem_resp_valid & ~dropping & ~redirect_valid;
    assign pop            = inst_valid & inst_ready;
    assign remain         = count - CW'(pop);
    assign rd_next        = rd_ptr + AW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_resp_data;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inst_valid  <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
        end else begin
            case (state)
                RUN:   if (!fetch_en) state <= DRAIN;
                DRAIN: if (fetch_en) state <= RUN;
            endcase
            outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                // Everything still in flight after this cycle's response belongs to the old path.
                fetch_pc   <= redirect_base;
                resp_pc    <= redirect_base;
                drop_cnt   <= outstanding - CW'(imem_resp_valid);
                count      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                inst_valid <= 1'b0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (imem_resp_valid && dropping) drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    resp_pc <= resp_pc + XLEN'(4);
                end
                count      <= remain + CW'(push);
                rd_ptr     <= rd_next;
                inst_valid <= (remain != '0) | push;
                // Head register reloads from storage, or from the incoming word when nothing older remains.
                if (remain != '0) begin
                    inst    <= q_data[rd_next];
                    inst_pc <= q_pc[rd_next];
                end else if (push) begin
                    inst    <= imem_resp_data;
                    inst_pc <= resp_pc;
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(push && !pop && count == FULL));
endmodule
